// File: rtl/split_target_pkg.sv
// Shared types and constants for the split-transaction bus target.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package split_target_pkg;

  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 8;
  // One serialiser load cycle plus eight bit times.
  localparam int TX_HOLD_CYCLES = 9;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    SPLIT_REQ,
    RESPOND,
    TX_HOLD
  } state_t;

endpackage

// File: rtl/split_target_mem.sv
// Single-port synchronous byte RAM with write enable and registered read data.
// Latency: write lands on the clock edge; read data valid one cycle after the address.
// Backpressure: none, accepts one access per cycle.
// Ports: clk; we write enable; addr byte index; wdata write byte; rdata registered read byte.
module split_target_mem
  import split_target_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  // Contents are deliberately not reset so data survives a bus reset.
  logic [DATA_W-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/split_target.sv
// Bus target: writes complete immediately with an ack, reads are answered via a split transaction.
// Latency: write ack next cycle; read split_req after READ_LATENCY+1 cycles, data one cycle after grant.
// Backpressure: target_ready low from read accept until the TX hold ends; requests there are dropped.
// Ports: clk/rst_n; target_addr_in(+_valid), target_data_in(+_valid), bus_rw, split_grant in;
//        target_rw, target_ready, target_ack, target_split_ack, split_req,
//        target_data_out(+_valid) out.
module split_target
  import split_target_pkg::*;
#(
  parameter int                                MEM_ADDR_BITS = 12,
  parameter logic [ADDR_W-MEM_ADDR_BITS-1:0]   BASE_ADDR     = 4'h1,
  parameter int                                READ_LATENCY  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] target_addr_in,
  input  logic              target_addr_in_valid,
  input  logic [DATA_W-1:0] target_data_in,
  input  logic              target_data_in_valid,
  input  logic              bus_rw,
  input  logic              split_grant,
  output logic              target_rw,
  output logic              target_ready,
  output logic              target_ack,
  output logic              target_split_ack,
  output logic              split_req,
  output logic [DATA_W-1:0] target_data_out,
  output logic              target_data_out_valid
);

  state_t                   state;
  logic [3:0]               cnt;
  logic [MEM_ADDR_BITS-1:0] rd_addr;
  logic [DATA_W-1:0]        rd_byte;
  logic [DATA_W-1:0]        mem_rdata;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic                     hit;
  logic                     wr_req;
  logic                     rd_req;

  assign target_rw = bus_rw;

  assign hit    = (target_addr_in[ADDR_W-1:MEM_ADDR_BITS] == BASE_ADDR);
  assign wr_req = (state == IDLE) && target_addr_in_valid && target_data_in_valid && hit;
  assign rd_req = (state == IDLE) && target_addr_in_valid && !target_data_in_valid && hit;

  // In IDLE the RAM sees the live bus address, so the first fetch starts in the
  // accept cycle itself; afterwards it keeps re-reading the latched address.
  // This keeps READ_LATENCY=1 working and makes a read right after a write see the new byte.
  assign mem_addr = (state == IDLE) ? target_addr_in[MEM_ADDR_BITS-1:0] : rd_addr;

  split_target_mem #(
    .ADDR_BITS (MEM_ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (wr_req),
    .addr  (mem_addr),
    .wdata (target_data_in),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      cnt                   <= 4'd0;
      rd_addr               <= '0;
      rd_byte               <= '0;
      target_ready          <= 1'b1;
      target_ack            <= 1'b0;
      target_split_ack      <= 1'b0;
      split_req             <= 1'b0;
      target_data_out       <= '0;
      target_data_out_valid <= 1'b0;
    end else begin
      target_ack            <= 1'b0;
      target_split_ack      <= 1'b0;
      target_data_out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) begin
            target_ack <= 1'b1;
          end else if (rd_req) begin
            rd_addr          <= target_addr_in[MEM_ADDR_BITS-1:0];
            target_split_ack <= 1'b1;
            target_ready     <= 1'b0;
            cnt              <= 4'(READ_LATENCY);
            state            <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (cnt == 4'd1) begin
            rd_byte   <= mem_rdata;
            split_req <= 1'b1;
            cnt       <= 4'd0;
            state     <= SPLIT_REQ;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SPLIT_REQ: begin
          if (split_grant) begin
            target_data_out       <= rd_byte;
            target_data_out_valid <= 1'b1;
            state                 <= RESPOND;
          end
        end
        RESPOND: begin
          cnt   <= 4'(TX_HOLD_CYCLES);
          state <= TX_HOLD;
        end
        TX_HOLD: begin
          // split_req stays asserted while the serialiser shifts the byte out.
          if (cnt == 4'd1) begin
            split_req    <= 1'b0;
            target_ready <= 1'b1;
            cnt          <= 4'd0;
            state        <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_split_target.sv
// Randomized bench for split_target with a timeline-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_split_target;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] target_addr_in = '0;
  logic        target_addr_in_valid = 1'b0;
  logic [7:0]  target_data_in = '0;
  logic        target_data_in_valid = 1'b0;
  logic        bus_rw = 1'b0;
  logic        split_grant = 1'b0;
  logic        target_rw, target_ready, target_ack, target_split_ack, split_req;
  logic [7:0]  target_data_out;
  logic        target_data_out_valid;

  split_target #(
    .MEM_ADDR_BITS (12),
    .BASE_ADDR     (4'h1),
    .READ_LATENCY  (L)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .target_addr_in        (target_addr_in),
    .target_addr_in_valid  (target_addr_in_valid),
    .target_data_in        (target_data_in),
    .target_data_in_valid  (target_data_in_valid),
    .bus_rw                (bus_rw),
    .split_grant           (split_grant),
    .target_rw             (target_rw),
    .target_ready          (target_ready),
    .target_ack            (target_ack),
    .target_split_ack      (target_split_ack),
    .split_req             (split_req),
    .target_data_out       (target_data_out),
    .target_data_out_valid (target_data_out_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (period %0d)", name, act, exp, n);
    end
  endtask

  // Reference model: a read is described only by the period it was accepted
  // (rd_n) and the period its grant was sampled (grant_n); every output is a
  // plain arithmetic function of those times and the current period n.
  int         n       = 0;
  int         rd_n    = -1;
  int         grant_n = -1;
  int         wr_n    = -100;
  logic [7:0] rd_byte = '0;
  logic [7:0] mem_m [int];
  logic       exp_ready, exp_ack, exp_sack, exp_sreq, exp_dv;
  logic [7:0] exp_dout = '0;

  function automatic void compute_exp();
    bit active;
    if (rd_n >= 0 && grant_n >= 0 && n > grant_n + 10) begin
      rd_n    = -1;
      grant_n = -1;
    end
    active    = (rd_n >= 0) && (n >= rd_n + 1);
    exp_ready = !active;
    exp_sack  = (rd_n >= 0) && (n == rd_n + 1);
    exp_sreq  = active && (n >= rd_n + 1 + L);
    exp_dv    = (grant_n >= 0) && (n == grant_n + 1);
    if (exp_dv) exp_dout = rd_byte;
    exp_ack   = (wr_n == n - 1);
  endfunction

  function automatic void model_reset();
    rd_n     = -1;
    grant_n  = -1;
    wr_n     = -100;
    exp_dout = '0;
    compute_exp();
  endfunction

  // Consume the inputs sampled at the edge just passed (period n) and predict period n+1.
  function automatic void model_step();
    int off;
    off = int'(target_addr_in[11:0]);
    if (exp_ready) begin
      if (target_addr_in_valid && target_addr_in[15:12] == 4'h1) begin
        if (target_data_in_valid) begin
          mem_m[off] = target_data_in;
          wr_n       = n;
        end else begin
          rd_n    = n;
          grant_n = -1;
          rd_byte = mem_m.exists(off) ? mem_m[off] : 8'hxx;
        end
      end
    end else if (rd_n >= 0 && grant_n < 0 && n >= rd_n + 1 + L && split_grant) begin
      grant_n = n;
    end
    n++;
    compute_exp();
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready",     target_ready,          exp_ready);
      check("ack",       target_ack,            exp_ack);
      check("split_ack", target_split_ack,      exp_sack);
      check("split_req", split_req,             exp_sreq);
      check("dout_vld",  target_data_out_valid, exp_dv);
      check("dout",      target_data_out,       exp_dout);
      check("rw",        target_rw,             bus_rw);
    end
  end

  task automatic tick(input logic av, input logic dv, input logic [15:0] a,
                      input logic [7:0] d, input logic g);
    target_addr_in_valid = av;
    target_data_in_valid = dv;
    target_addr_in       = a;
    target_data_in       = d;
    split_grant          = g;
    bus_rw               = 1'($urandom);
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
  endtask

  logic [15:0] pool [6] = '{16'h1034, 16'h1000, 16'h1FFF, 16'h1100, 16'h2034, 16'h0034};

  initial begin
    model_reset();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", target_ready, 1'b1);
    check("rst_sreq",  split_req,    1'b0);
    check("rst_dout",  target_data_out, 8'h00);
    rst_n = 1'b1;

    // Write, pulse-width, preload.
    tick(1'b1, 1'b1, 16'h1034, 8'hA5, 1'b0);
    check("wr_ack_1034", target_ack, 1'b1);
    tick(1'b1, 1'b1, 16'h1000, 8'h11, 1'b0);
    tick(1'b1, 1'b1, 16'h1FFF, 8'hEE, 1'b0);
    idle(1);
    check("wr_ack_pulse", target_ack, 1'b0);

    // Out-of-window address: aliases 0x034 but must not touch memory.
    tick(1'b1, 1'b1, 16'h2034, 8'h77, 1'b0);
    check("bad_wr_ack", target_ack, 1'b0);
    tick(1'b1, 1'b0, 16'h2034, 8'h00, 1'b0);
    check("bad_rd_sack",  target_split_ack, 1'b0);
    check("bad_rd_ready", target_ready,     1'b1);

    // Read of 0x1034 with a dropped write during READ_WAIT.
    tick(1'b1, 1'b0, 16'h1034, 8'h00, 1'b0);             // now N+1
    check("rd_sack_n1",  target_split_ack, 1'b1);
    check("rd_ready_n1", target_ready,     1'b0);
    tick(1'b1, 1'b1, 16'h1034, 8'h5A, 1'b0);             // N+2
    check("drop_wr_ack", target_ack, 1'b0);
    idle(2);                                              // N+4
    check("sreq_n4", split_req, 1'b0);
    idle(1);                                              // N+5
    check("sreq_n5", split_req, 1'b1);
    idle(2);                                              // N+7, still waiting
    check("sreq_hold", split_req, 1'b1);
    tick(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);             // grant at G, now G+1
    check("dv_g1",   target_data_out_valid, 1'b1);
    check("dout_g1", target_data_out,       8'hA5);
    idle(1);                                              // G+2
    check("dv_g2", target_data_out_valid, 1'b0);
    idle(8);                                              // G+10
    check("sreq_g10",  split_req,    1'b1);
    check("ready_g10", target_ready, 1'b0);
    idle(1);                                              // G+11
    check("sreq_g11",  split_req,    1'b0);
    check("ready_g11", target_ready, 1'b1);
    check("dout_hold", target_data_out, 8'hA5);

    // Write immediately followed by a read of the same byte.
    tick(1'b1, 1'b1, 16'h1100, 8'h3C, 1'b0);
    tick(1'b1, 1'b0, 16'h1100, 8'h00, 1'b0);
    idle(4);
    tick(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    check("wr_then_rd", target_data_out, 8'h3C);
    idle(10);

    // Reset in the middle of TX_HOLD.
    tick(1'b1, 1'b0, 16'h1000, 8'h00, 1'b0);
    idle(4);
    tick(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    idle(3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sreq",  split_req,    1'b0);
    check("mid_rst_ready", target_ready, 1'b1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n++;
    compute_exp();
    tick(1'b1, 1'b0, 16'h1034, 8'h00, 1'b0);
    idle(4);
    tick(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    check("post_rst_rd", target_data_out, 8'hA5);
    idle(10);

    // Random traffic; reads only target preloaded or out-of-window addresses.
    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom), 1'($urandom), pool[$urandom_range(0, 5)], 8'($urandom),
           ($urandom_range(0, 3) == 0));
    end
    idle(20);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
